// File: rtl/arb_pkg.sv
// ============================================================================
// Module   : arb_pkg
// Purpose  : Shared types and constants for the data memory arbiter.
//            - owner_e            : current owner of the data RAM port
//            - DEF_ADDR_WIDTH/DEF_DATA_WIDTH : default port widths
//            - hold_cnt_width()   : width of the contention counter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  // Bits needed to hold the values 0..max_hold inclusive.
  function automatic int hold_cnt_width(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_hold_counter.sv
// ============================================================================
// Module   : arb_hold_counter
// Purpose  : Saturating contention counter. Counts consecutive grants to the
//            same owner while the other side waits.
// Ports    : clk, reset (sync, active-low)
//            clear   - next value 0
//            restart - next value 1 (ownership changed, loser still waiting)
//            inc     - next value +1, saturating at MAX_VAL
//            cnt     - current count
//            Priority: inc > restart > clear > hold.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_hold_counter #(
  parameter int WIDTH   = 3,
  parameter int MAX_VAL = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             restart,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      cnt_d = (cnt_q >= C_MAX) ? C_MAX : cnt_q + C_ONE;
    end else if (restart) begin
      cnt_d = C_ONE;
    end else if (clear) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/data_memory_arbiter.sv
// ============================================================================
// Module   : data_memory_arbiter
// Purpose  : Shares the single data RAM between the core load/store path and
//            an external master. One access per cycle, fixed CPU priority
//            when idle, with a starvation limit of MAX_HOLD consecutive
//            grants while the other side waits.
// Ports    : clk, reset (sync, active-low)
//            cpu_req/we/addr/wdata -> cpu_gnt, cpu_stall, cpu_rdata (comb)
//            ext_req/we/addr/wdata -> ext_gnt, ext_rvalid/ext_rdata (reg)
//            mem_addr/wdata/write/read -> RAM, mem_rdata <- RAM (async)
// Options  : ARB_STATS_EN adds cpu_stall_cnt / ext_wait_cnt (saturating).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]           cpu_stall_cnt,
  output logic [31:0]           ext_wait_cnt
`endif
);

  localparam int               HOLD_W   = hold_cnt_width(MAX_HOLD);
  localparam logic [HOLD_W-1:0] C_HOLD_MAX = HOLD_W'(MAX_HOLD);

  owner_e                  owner_q, owner_d;
  logic                    resetting_q;
  logic                    ext_rvalid_q, ext_rvalid_d;
  logic [DATA_WIDTH-1:0]   ext_rdata_q, ext_rdata_d;
  logic [HOLD_W-1:0]       hold_cnt;
  logic                    hold_at_max;
  logic                    keep_owner;
  logic                    other_active;

  assign hold_at_max = (hold_cnt >= C_HOLD_MAX);

  // Grants are blocked for every cycle after a reset edge until reset is
  // sampled high again. The cycle in which reset is first asserted still
  // grants normally, so a write in flight reaches the RAM (it has no reset).
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    if (!resetting_q) begin
      if (cpu_req && !ext_req) begin
        cpu_gnt = 1'b1;
      end else if (ext_req && !cpu_req) begin
        ext_gnt = 1'b1;
      end else if (cpu_req && ext_req) begin
        case (owner_q)
          OWN_CPU: begin
            cpu_gnt = !hold_at_max;
            ext_gnt = hold_at_max;
          end
          OWN_EXT: begin
            ext_gnt = !hold_at_max;
            cpu_gnt = hold_at_max;
          end
          default: cpu_gnt = 1'b1;
        endcase
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign cpu_rdata = cpu_gnt ? mem_rdata : '0;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_write = cpu_we;
      mem_read  = ~cpu_we;
    end else if (ext_gnt) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_write = ext_we;
      mem_read  = ~ext_we;
    end
  end

  // Owner / contention bookkeeping. "other_active" is the non-granted side
  // still requesting; without it the counter clears.
  always_comb begin
    owner_d      = OWN_NONE;
    other_active = 1'b0;
    if (cpu_gnt) begin
      owner_d      = OWN_CPU;
      other_active = ext_req;
    end else if (ext_gnt) begin
      owner_d      = OWN_EXT;
      other_active = cpu_req;
    end
    keep_owner = (owner_d != OWN_NONE) && (owner_d == owner_q);
  end

  arb_hold_counter #(
    .WIDTH   (HOLD_W),
    .MAX_VAL (MAX_HOLD)
  ) u_hold_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (!other_active),
    .restart (!keep_owner && other_active),
    .inc     (keep_owner && other_active),
    .cnt     (hold_cnt)
  );

  always_comb begin
    ext_rvalid_d = ext_gnt & ~ext_we;
    ext_rdata_d  = ext_rvalid_d ? mem_rdata : ext_rdata_q;
  end

  always_ff @(posedge clk) begin
    resetting_q <= ~reset;
    if (!reset) begin
      owner_q      <= OWN_NONE;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      owner_q      <= owner_d;
      ext_rvalid_q <= ext_rvalid_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  assign ext_rvalid = ext_rvalid_q;
  assign ext_rdata  = ext_rdata_q;

`ifdef ARB_STATS_EN
  logic [31:0] cpu_stall_cnt_q, cpu_stall_cnt_d;
  logic [31:0] ext_wait_cnt_q,  ext_wait_cnt_d;

  always_comb begin
    cpu_stall_cnt_d = cpu_stall_cnt_q;
    ext_wait_cnt_d  = ext_wait_cnt_q;
    if (cpu_stall && (cpu_stall_cnt_q != 32'hFFFF_FFFF)) begin
      cpu_stall_cnt_d = cpu_stall_cnt_q + 32'd1;
    end
    if (ext_req && !ext_gnt && (ext_wait_cnt_q != 32'hFFFF_FFFF)) begin
      ext_wait_cnt_d = ext_wait_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_stall_cnt_q <= '0;
      ext_wait_cnt_q  <= '0;
    end else begin
      cpu_stall_cnt_q <= cpu_stall_cnt_d;
      ext_wait_cnt_q  <= ext_wait_cnt_d;
    end
  end

  assign cpu_stall_cnt = cpu_stall_cnt_q;
  assign ext_wait_cnt  = ext_wait_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
// ============================================================================
// Module   : tb_data_memory_arbiter
// Purpose  : Self-checking bench for data_memory_arbiter with a byte-wide
//            1024-deep RAM model (async read, sync write, big-endian words).
//            Build with ARB_STATS_EN defined to also cover the counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_stall;
  logic [31:0] cpu_rdata;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_write, mem_read;
  logic [31:0] mem_rdata;
`ifdef ARB_STATS_EN
  logic [31:0] cpu_stall_cnt, ext_wait_cnt;
`endif

  int checks = 0;
  int passes = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  data_memory_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MAX_HOLD   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata)
`ifdef ARB_STATS_EN
    ,
    .cpu_stall_cnt (cpu_stall_cnt),
    .ext_wait_cnt  (ext_wait_cnt)
`endif
  );

  // RAM model
  logic [7:0] ram [0:1023] = '{default: 8'h00};
  logic [9:0] ra;
  assign ra = mem_addr[9:0];
  assign mem_rdata = {ram[ra], ram[ra + 10'd1], ram[ra + 10'd2], ram[ra + 10'd3]};
  always @(posedge clk) begin
    if (mem_write === 1'b1) begin
      ram[ra]         <= mem_wdata[31:24];
      ram[ra + 10'd1] <= mem_wdata[23:16];
      ram[ra + 10'd2] <= mem_wdata[15:8];
      ram[ra + 10'd3] <= mem_wdata[7:0];
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drive_ext(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    ext_req = req; ext_we = we; ext_addr = a; ext_wdata = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_cpu(1'b1, 1'b1, 32'h80, 32'h1111_1111);
    drive_ext(1'b1, 1'b1, 32'h84, 32'h2222_2222);
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (cpu_gnt !== 1'b0) $display("FAIL rst_cpu_gnt got %b want 0", cpu_gnt); else passes++;
    checks++; if (ext_gnt !== 1'b0) $display("FAIL rst_ext_gnt got %b want 0", ext_gnt); else passes++;
    checks++; if (mem_write !== 1'b0) $display("FAIL rst_mem_write got %b want 0", mem_write); else passes++;
    checks++; if (ext_rvalid !== 1'b0) $display("FAIL rst_ext_rvalid got %b want 0", ext_rvalid); else passes++;
    // release: both read, first cycle after reset is sampled high goes to CPU
    drive_cpu(1'b1, 1'b0, 32'h80, 32'h0);
    drive_ext(1'b1, 1'b0, 32'h84, 32'h0);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++; if ({cpu_gnt, ext_gnt} !== 2'b10) $display("FAIL rel_gnt got %b want 10", {cpu_gnt, ext_gnt}); else passes++;
    checks++; if (cpu_stall !== 1'b0) $display("FAIL rel_stall got %b want 0", cpu_stall); else passes++;
    next_cycle();
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if ({cpu_gnt, ext_gnt, mem_write, mem_read, cpu_stall} !== 5'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      $display("FAIL idle_outputs got gnt=%b%b wr=%b rd=%b addr=%h want all 0", cpu_gnt, ext_gnt, mem_write, mem_read, mem_addr);
    else passes++;
  endtask

  task automatic test_cpu_alone();
    next_cycle();
    drive_cpu(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++;
    if ({cpu_gnt, cpu_stall, mem_write, mem_read} !== 4'b1010 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF)
      $display("FAIL cpu_write got gnt=%b stall=%b wr=%b rd=%b addr=%h wd=%h want 1 0 1 0 10 deadbeef",
               cpu_gnt, cpu_stall, mem_write, mem_read, mem_addr, mem_wdata);
    else passes++;
    next_cycle();
    drive_cpu(1'b1, 1'b0, 32'h10, 32'h0);
    sb_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    checks++; if ({cpu_gnt, cpu_stall, mem_read} !== 3'b101) $display("FAIL cpu_read_gnt got %b want 101", {cpu_gnt, cpu_stall, mem_read}); else passes++;
    checks++;
    if (cpu_gnt === 1'b1 && sb_q.size() > 0) begin
      logic [31:0] exp = sb_q.pop_front();
      if (cpu_rdata !== exp) $display("FAIL cpu_rdata got %h want %h", cpu_rdata, exp); else passes++;
    end else $display("FAIL cpu_rdata no grant to compare");
    next_cycle();
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (cpu_rdata !== 32'h0) $display("FAIL cpu_rdata_idle got %h want 0", cpu_rdata); else passes++;
  endtask

  task automatic test_ext_read();
    next_cycle();
    drive_ext(1'b1, 1'b1, 32'h20, 32'h1234_5678);
    @(negedge clk);
    checks++; if ({ext_gnt, mem_write} !== 2'b11 || mem_addr !== 32'h20) $display("FAIL ext_write got gnt=%b wr=%b addr=%h", ext_gnt, mem_write, mem_addr); else passes++;
    next_cycle();
    drive_ext(1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    checks++; if ({ext_gnt, mem_read, ext_rvalid} !== 3'b110) $display("FAIL ext_read_gnt got %b want 110", {ext_gnt, mem_read, ext_rvalid}); else passes++;
    if (ext_gnt === 1'b1) sb_q.push_back(32'h1234_5678);
    next_cycle();
    drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (ext_rvalid === 1'b1 && sb_q.size() > 0) begin
      logic [31:0] exp = sb_q.pop_front();
      if (ext_rdata !== exp) $display("FAIL ext_rdata got %h want %h", ext_rdata, exp); else passes++;
    end else $display("FAIL ext_rvalid got %b want 1 one cycle after grant", ext_rvalid);
    next_cycle();
    @(negedge clk);
    checks++; if (ext_rvalid !== 1'b0 || ext_rdata !== 32'h1234_5678) $display("FAIL ext_rdata_hold got v=%b d=%h want 0 12345678", ext_rvalid, ext_rdata); else passes++;
    sb_q.delete();
  endtask

  task automatic test_contention();
`ifdef ARB_STATS_EN
    logic [31:0] stall0, wait0;
`endif
    next_cycle();
    @(negedge clk);
`ifdef ARB_STATS_EN
    stall0 = cpu_stall_cnt;
    wait0  = ext_wait_cnt;
`endif
    for (int i = 0; i < 16; i++) sb_q.push_back(((i / 4) % 2 == 0) ? 32'h4 : 32'h3);
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      drive_cpu(1'b1, 1'b0, 32'h10, 32'h0);
      drive_ext(1'b1, 1'b0, 32'h20, 32'h0);
      @(negedge clk);
      begin
        logic [31:0] exp = sb_q.pop_front();
        checks++;
        if ({cpu_gnt, ext_gnt, cpu_stall} !== exp[2:0])
          $display("FAIL contention_c%0d got gnt_cpu/gnt_ext/stall=%b want %b", i, {cpu_gnt, ext_gnt, cpu_stall}, exp[2:0]);
        else passes++;
      end
    end
    next_cycle();
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
`ifdef ARB_STATS_EN
    checks++; if (cpu_stall_cnt - stall0 !== 32'd8) $display("FAIL stats_stall got %0d want 8", cpu_stall_cnt - stall0); else passes++;
    checks++; if (ext_wait_cnt - wait0 !== 32'd8) $display("FAIL stats_wait got %0d want 8", ext_wait_cnt - wait0); else passes++;
`endif
  endtask

  task automatic test_drop_request();
    next_cycle();
    drive_cpu(1'b1, 1'b0, 32'h30, 32'h0);
    next_cycle();
    drive_ext(1'b1, 1'b1, 32'h30, 32'hBAD0_BAD0);
    @(negedge clk);
    checks++; if ({cpu_gnt, ext_gnt, mem_write} !== 3'b100) $display("FAIL drop_gnt got %b want 100", {cpu_gnt, ext_gnt, mem_write}); else passes++;
    next_cycle();
    drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (dut.u_hold_counter.cnt_q !== 3'd1) $display("FAIL drop_hold1 got %0d want 1", dut.u_hold_counter.cnt_q); else passes++;
    next_cycle();
    sb_q.push_back(32'h0);
    @(negedge clk);
    checks++; if (dut.u_hold_counter.cnt_q !== 3'd0) $display("FAIL drop_hold0 got %0d want 0", dut.u_hold_counter.cnt_q); else passes++;
    checks++;
    begin
      logic [31:0] exp = sb_q.pop_front();
      if (cpu_gnt !== 1'b1 || cpu_rdata !== exp) $display("FAIL drop_no_write got gnt=%b rdata=%h want 1 %h", cpu_gnt, cpu_rdata, exp); else passes++;
    end
    next_cycle();
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid();
    next_cycle();
    reset = 1'b0;
    drive_ext(1'b1, 1'b1, 32'h40, 32'hCAFE_F00D);
    @(negedge clk);
    checks++; if ({ext_gnt, mem_write} !== 2'b11) $display("FAIL midrst_write got %b want 11", {ext_gnt, mem_write}); else passes++;
    next_cycle();
    reset = 1'b1;
    drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
`ifdef ARB_STATS_EN
    checks++; if (cpu_stall_cnt !== 32'd0 || ext_wait_cnt !== 32'd0) $display("FAIL stats_reset got %0d %0d want 0 0", cpu_stall_cnt, ext_wait_cnt); else passes++;
`endif
    next_cycle();
    reset = 1'b0;
    drive_ext(1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    checks++; if (ext_gnt !== 1'b1) $display("FAIL midrst_read_gnt got %b want 1", ext_gnt); else passes++;
    next_cycle();
    reset = 1'b1;
    drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (ext_rvalid !== 1'b0 || ext_rdata !== 32'h0) $display("FAIL midrst_rvalid got v=%b d=%h want 0 0", ext_rvalid, ext_rdata); else passes++;
    next_cycle();
    next_cycle();
    drive_cpu(1'b1, 1'b0, 32'h40, 32'h0);
    sb_q.push_back(32'hCAFE_F00D);
    @(negedge clk);
    checks++;
    begin
      logic [31:0] exp = sb_q.pop_front();
      if (cpu_gnt !== 1'b1 || cpu_rdata !== exp) $display("FAIL midrst_commit got gnt=%b rdata=%h want 1 %h", cpu_gnt, cpu_rdata, exp); else passes++;
    end
    next_cycle();
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_cpu_alone();
    test_ext_read();
    test_contention();
    test_drop_request();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
